aes_inv_key_sched: RTL and testbench

AES_INV_KEY_SCHED -- requirements
Module: aes_inv_key_sched

---
 rtl/aes_inv_key_sched.sv | 229 ++++++++++++++++++++++
 tb/tb_aes_inv_key_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_sched.sv
// AES-128 key schedule streamer: walks round keys 10..0 from the round-10 key, one per handshake.
// Defining AES_KEYSCHED_FWD_EN adds a dir input selecting forward expansion (rounds 0..10 from the cipher key).

module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0), then the fixed affine transform.
  function automatic logic [7:0] sboxCalc(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    logic [7:0] b;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gfMul(sq, sq);
      inv = gfMul(inv, sq);
    end
    b = inv;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  assign out_o = sboxCalc(in_i);

endmodule

module aes_inv_key_sched (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         rk_ready,
`ifdef AES_KEYSCHED_FWD_EN
  input  logic         dir,
`endif
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [3:0]   idx_q, idx_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
`ifdef AES_KEYSCHED_FWD_EN
  logic         dir_q, dir_d;
`endif

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  logic [31:0] k0, k1, k2, k3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] sub_in, sub_rot, sub_out;

  assign k0 = key_q[127:96];
  assign k1 = key_q[95:64];
  assign k2 = key_q[63:32];
  assign k3 = key_q[31:0];

  assign p3 = k3 ^ k2;
  assign p2 = k2 ^ k1;
  assign p1 = k1 ^ k0;

  // Both directions share the four S-boxes; only the word fed to RotWord differs.
`ifdef AES_KEYSCHED_FWD_EN
  assign sub_in = dir_q ? k3 : p3;
`else
  assign sub_in = p3;
`endif
  assign sub_rot = {sub_in[23:0], sub_in[31:24]};

  aes_sbox u_sbox3 (.in_i(sub_rot[31:24]), .out_o(sub_out[31:24]));
  aes_sbox u_sbox2 (.in_i(sub_rot[23:16]), .out_o(sub_out[23:16]));
  aes_sbox u_sbox1 (.in_i(sub_rot[15:8]),  .out_o(sub_out[15:8]));
  aes_sbox u_sbox0 (.in_i(sub_rot[7:0]),   .out_o(sub_out[7:0]));

  assign p0 = k0 ^ sub_out ^ {rcon(idx_q), 24'h0};

  logic [127:0] step_key;
  logic [3:0]   step_idx;
  logic         last_round;

`ifdef AES_KEYSCHED_FWD_EN
  logic [31:0] n0, n1, n2, n3;
  logic [3:0]  idx_inc;

  assign idx_inc = idx_q + 4'd1;
  assign n0 = k0 ^ sub_out ^ {rcon(idx_inc), 24'h0};
  assign n1 = k1 ^ n0;
  assign n2 = k2 ^ n1;
  assign n3 = k3 ^ n2;

  always_comb begin
    step_key   = {p0, p1, p2, p3};
    step_idx   = idx_q - 4'd1;
    last_round = (idx_q == 4'd0);
    if (dir_q) begin
      step_key   = {n0, n1, n2, n3};
      step_idx   = idx_inc;
      last_round = (idx_q == 4'd10);
    end
  end
`else
  always_comb begin
    step_key   = {p0, p1, p2, p3};
    step_idx   = idx_q - 4'd1;
    last_round = (idx_q == 4'd0);
  end
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef AES_KEYSCHED_FWD_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          key_d   = key_in;
          valid_d = 1'b1;
          busy_d  = 1'b1;
`ifdef AES_KEYSCHED_FWD_EN
          dir_d   = dir;
          idx_d   = dir ? 4'd0 : 4'd10;
`else
          idx_d   = 4'd10;
`endif
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (last_round) begin
            state_d = FIN;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            key_d = step_key;
            idx_d = step_idx;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AES_KEYSCHED_FWD_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef AES_KEYSCHED_FWD_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign rk_valid  = valid_q;
  assign round_key = key_q;
  assign round_idx = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Scoreboard bench for aes_inv_key_sched: expected round keys come from a textbook forward
// AES-128 expansion; a negedge monitor compares every valid cycle and tracks done pulses.

module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         rk_ready = 1'b0;
`ifdef AES_KEYSCHED_FWD_EN
  logic         dir = 1'b0;
`endif
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  aes_inv_key_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .rk_ready  (rk_ready),
`ifdef AES_KEYSCHED_FWD_EN
    .dir       (dir),
`endif
    .rk_valid  (rk_valid),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           last;
  } exp_t;

  exp_t         sbQ[$];
  int           checks = 0;
  int           errors = 0;
  bit           expectDone = 1'b0;
  int           readyMode = 0;
  logic [7:0]   sboxTbl [256];
  logic [127:0] refKeys [11];

  // Table built by walking the multiplicative group with generator 3, independent of the RTL S-box.
  task automatic buildSbox();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sboxTbl[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sboxTbl[0] = 8'h63;
  endtask

  task automatic expandKey(input logic [127:0] ck);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = ck[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sboxTbl[t[31:24]], sboxTbl[t[23:16]], sboxTbl[t[15:8]], sboxTbl[t[7:0]]};
        t  = t ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) refKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Pushes the expected schedule for cipher key ck, then issues a one-cycle start.
  task automatic applyStimulus(input logic [127:0] ck, input bit fwd, input bit knownVec);
    logic [127:0] k;
    exp_t         e;
    expandKey(ck);
    for (int n = 0; n < 11; n++) begin
      e.idx  = fwd ? 4'(n) : 4'(10 - n);
      k      = refKeys[e.idx];
      if (knownVec) begin
        if (e.idx == 4'd10) k = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        if (!fwd && e.idx == 4'd9) k = 128'hac7766f319fadc2128d12941575c006e;
        if (e.idx == 4'd1 && fwd) k = 128'ha0fafe1788542cb123a339392a6c7605;
        if (e.idx == 4'd0) k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      end
      e.key  = k;
      e.last = (n == 10);
      sbQ.push_back(e);
    end
    @(posedge clk); #1;
    start  = 1'b1;
    key_in = fwd ? ck : refKeys[10];
`ifdef AES_KEYSCHED_FWD_EN
    dir    = fwd;
`endif
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic waitIdle(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (sbQ.size() == 0 && !expectDone && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checkOutput({name, " completion timeout"}, 128'(sbQ.size()), 128'd0);
      sbQ.delete();
      expectDone = 1'b0;
    end
  endtask

  task automatic waitRound(input logic [3:0] r, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (rk_valid && round_idx == r) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("wait for round timeout", 128'(round_idx), 128'(r));
  endtask

  // Monitor: every valid cycle must show the head of the scoreboard, held until the handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (expectDone) begin
        checkOutput("done pulse", 128'(done), 128'd1);
        expectDone = 1'b0;
      end else if (done) begin
        checkOutput("spurious done", 128'(done), 128'd0);
      end
      if (rk_valid) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected rk_valid", 128'(rk_valid), 128'd0);
        end else begin
          checkOutput("round_idx", 128'(round_idx), 128'(sbQ[0].idx));
          checkOutput("round_key", round_key, sbQ[0].key);
          if (rk_ready) begin
            if (sbQ[0].last) expectDone = 1'b1;
            void'(sbQ.pop_front());
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        0:       rk_ready = 1'b1;
        1:       rk_ready = ~rk_ready;
        default: rk_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    logic [127:0] kb;
    buildSbox();

    #3;
    checkOutput("reset rk_valid", 128'(rk_valid), 128'd0);
    checkOutput("reset done", 128'(done), 128'd0);
    checkOutput("reset busy", 128'(busy), 128'd0);
    checkOutput("reset round_key", round_key, 128'd0);
    checkOutput("reset round_idx", 128'(round_idx), 128'd0);
    #9 rst_n = 1'b1;

    $display("[TB] known vector, rk_ready always high");
    readyMode = 0;
    applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b1);
    waitIdle("known vector");

    $display("[TB] known vector, rk_ready toggling");
    readyMode = 1;
    applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b1);
    waitIdle("toggling ready");

    $display("[TB] start pulsed during round 5");
    readyMode = 0;
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    waitRound(4'd5, ok);
    @(posedge clk); #1;
    start  = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    start  = 1'b0;
    waitIdle("start mid-schedule");

    $display("[TB] asynchronous reset at round 4");
    readyMode = 2;
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    waitRound(4'd4, ok);
    #2 rst_n = 1'b0;
    sbQ.delete();
    expectDone = 1'b0;
    #1;
    checkOutput("abort rk_valid", 128'(rk_valid), 128'd0);
    checkOutput("abort done", 128'(done), 128'd0);
    checkOutput("abort busy", 128'(busy), 128'd0);
    checkOutput("abort round_key", round_key, 128'd0);
    checkOutput("abort round_idx", 128'(round_idx), 128'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    waitIdle("after reset");

    $display("[TB] randomized reverse schedules");
    for (int t = 0; t < 6; t++) begin
      readyMode = 2;
      applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
      waitIdle("random reverse");
    end

`ifdef AES_KEYSCHED_FWD_EN
    $display("[TB] forward mode");
    readyMode = 0;
    applyStimulus(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1, 1'b1);
    waitIdle("forward known vector");
    for (int t = 0; t < 3; t++) begin
      readyMode = 2;
      applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
      waitIdle("random forward");
    end
`endif

    $display("[TB] start held high across done");
    readyMode = 0;
    kb = {$urandom, $urandom, $urandom, $urandom};
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    start = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("held start first done", 128'(ok), 128'd1);
    expandKey(kb);
    for (int n = 0; n < 11; n++) sbQ.push_back('{idx: 4'(10 - n), key: refKeys[10 - n], last: (n == 10)});
    key_in = refKeys[10];
    @(negedge clk); #1;
    checkOutput("held start idle rk_valid", 128'(rk_valid), 128'd0);
    checkOutput("held start idle busy", 128'(busy), 128'd0);
    @(negedge clk); #1;
    checkOutput("held start restart rk_valid", 128'(rk_valid), 128'd1);
    checkOutput("held start restart idx", 128'(round_idx), 128'd10);
    @(posedge clk); #1;
    start = 1'b0;
    waitIdle("held start second schedule");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
